data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-requester arbiter and sequencer for the 128 x 8 data memory (synchronous write, registered read with one-cycle latency). It sits between the memory and two masters, the core load/store path (requester 0) and the loader/debug path (requester 1). It grants at most one access per cycle by round-robin, drives the memory control and address/data lines, and steers registered read data back to the issuing requester. A bounded lock lets one requester perform an atomic multi-access sequence.

## Interface
Parameters:
- ADDR_WIDTH, 7, memory line-number width (128 lines)
- DATA_WIDTH, 8, memory word width
- LOCK_MAX, 16, maximum consecutive cycles a lock may be held before forced release (≥ 1)

Ports (N = 0, 1 for per-requester ports):
- clk  input  1  single clock; every register updates on its rising edge
- reset  input  1  synchronous, active-high reset
- reqN  input  1  requester N has an access presented this cycle
- weN  input  1  1 = write, 0 = read (qualified by reqN)
- addrN  input  ADDR_WIDTH  line number
- wdataN  input  DATA_WIDTH  write data
- lockN  input  1  hold exclusive ownership after this access
- gntN  output  1  access accepted this cycle (combinational)
- rvalidN  output  1  rdataN holds read data for N's read granted last cycle (registered)
- rdataN  output  DATA_WIDTH  read data, equal to memOut; meaningful only while rvalidN is high
- memRead  output  1  memory read enable
- memWrite  output  1  memory write enable
- lineNumber  output  ADDR_WIDTH  memory address
- memIn  output  DATA_WIDTH  memory write data
- memOut  input  DATA_WIDTH  memory registered read data

## Operation
- Handshake: requester holds reqN/weN/addrN/wdataN/lockN stable until it sees gntN high; the access completes at that rising edge.
- Grant is one-hot or zero. gnt0 and gnt1 are never both high.
- Memory drive: when gntN is high, memWrite = weN and memRead = !weN, with lineNumber = addrN and memIn = wdataN. With no grant, memRead = memWrite = 0 and lineNumber/memIn = 0.
- Round-robin: a priority pointer (reset value 0) names the favoured requester. With both requesting and no lock active, the favoured one wins. After any grant to N, the pointer moves to the other requester. A lone requester is always granted.
- Lock FSM has three states: UNLOCKED, LOCKED0, LOCKED1.
  - UNLOCKED → LOCKEDN when N is granted with lockN = 1.
  - In LOCKEDN only requester N may be granted. Cycles with reqN low leave the memory idle.
  - LOCKEDN → UNLOCKED when N is granted with lockN = 0.
  - A counter clears on entering LOCKEDN and increments each cycle in LOCKEDN.
  - Forced release when the counter equals LOCK_MAX. That cycle arbitrates as UNLOCKED with the pointer forced to the non-owner, and all lock inputs are ignored. The next state is UNLOCKED.
- Read return: a read granted to N in cycle t sets rvalidN high in cycle t+1 only, with rdataN = memOut.

## Timing
- Grant and memory controls are combinational from the request inputs and the registered state: 0 cycles.
- Read latency: rvalidN is high exactly one cycle after the granted read. Back-to-back reads give a continuous rvalid stream.
- Write followed by a read of the same line in the next cycle returns the new data, because the memory write lands at the grant edge.
- Throughput: one access per cycle, sustained.
- While reset is high:
  - gnt0 = gnt1 = 0.
  - memRead = memWrite = 0.
  - After the edge: rvalid0 = rvalid1 = 0, pointer = 0, state UNLOCKED, lock counter = 0.
- Reset mid-operation:
  - A lock is dropped.
  - A read granted in the cycle before the reset edge produces no rvalid.
  - Requests held through reset are arbitrated normally from the first cycle with reset low.

## Test plan
- Reset, then write 0xA5 to line 3 via requester 0 and read line 3 via requester 1 on the next cycle → gnt0 then gnt1; rvalid1 high one cycle later with rdata1 = 0xA5; rvalid0 stays 0.
- Both requesters request continuously: requester 0 reads lines 0–3, requester 1 writes lines 10–13 → grants alternate 0,1,0,1,… starting with 0; never both high.
- Requester 0 does lock=1 read of line 5, then idles 2 cycles while requester 1 requests, then lock=0 write of line 5 → gnt1 stays 0 for all 4 cycles; requester 1 is granted the cycle after the unlock.
- LOCK_MAX = 4: requester 0 holds req0 = lock0 = 1 while requester 1 requests → forced release after 4 locked cycles; requester 1 is granted in the release cycle; requester 0 is not re-locked.
- Requester 1 read granted, reset asserted on the next edge → rvalid1 never asserts; all outputs are 0 during reset; the first post-reset contention is won by requester 0.
- Single requester reads lines 127 then 0 back-to-back → two consecutive rvalid cycles with correct data; lineNumber wraps correctly, no extra cycles.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the data memory and data_mem_arbiter.
// The slave side is the arbiter; the master side is the requesters plus the memory.
interface data_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
);
    logic                  req0;
    logic                  we0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  lock0;
    logic                  gnt0;
    logic                  rvalid0;
    logic [DATA_WIDTH-1:0] rdata0;

    logic                  req1;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  lock1;
    logic                  gnt1;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata1;

    logic                  memRead;
    logic                  memWrite;
    logic [ADDR_WIDTH-1:0] lineNumber;
    logic [DATA_WIDTH-1:0] memIn;
    logic [DATA_WIDTH-1:0] memOut;

    modport slave (
        input  req0, we0, addr0, wdata0, lock0,
        input  req1, we1, addr1, wdata1, lock1,
        input  memOut,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output memRead, memWrite, lineNumber, memIn
    );

    modport master (
        output req0, we0, addr0, wdata0, lock0,
        output req1, we1, addr1, wdata1, lock1,
        output memOut,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  memRead, memWrite, lineNumber, memIn
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter for the 128x8 data memory with a bounded exclusive lock
// and one-cycle registered read-data return steering.
module data_mem_arbiter #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int LOCK_MAX   = 16
) (
    input logic              clk,
    input logic              reset,
    data_mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} lock_state_t;

    lock_state_t   state, state_next;
    logic          ptr, ptr_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          rvalid0_q, rvalid1_q;
    logic          force_release;
    logic          prio;
    logic          win0, win1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= UNLOCKED;
            ptr       <= 1'b0;
            cnt       <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            cnt       <= cnt_next;
            rvalid0_q <= win0 && !bus.we0;
            rvalid1_q <= win1 && !bus.we1;
        end
    end

    // A forced release arbitrates as unlocked with the non-owner favoured.
    always_comb begin
        force_release = (state != UNLOCKED) && (cnt == CW'(LOCK_MAX));
        prio = ptr;
        win0 = 1'b0;
        win1 = 1'b0;
        if (!reset) begin
            if (state == LOCKED0 && !force_release) begin
                win0 = bus.req0;
            end else if (state == LOCKED1 && !force_release) begin
                win1 = bus.req1;
            end else begin
                if (force_release) prio = (state == LOCKED0);
                if (bus.req0 && bus.req1) begin
                    win0 = !prio;
                    win1 = prio;
                end else begin
                    win0 = bus.req0;
                    win1 = bus.req1;
                end
            end
        end

        ptr_next = ptr;
        if (win0)               ptr_next = 1'b1;
        else if (win1)          ptr_next = 1'b0;
        else if (force_release) ptr_next = prio;

        state_next = state;
        cnt_next   = cnt;
        case (state)
            UNLOCKED: begin
                if (win0 && bus.lock0) begin
                    state_next = LOCKED0;
                    cnt_next   = '0;
                end else if (win1 && bus.lock1) begin
                    state_next = LOCKED1;
                    cnt_next   = '0;
                end
            end
            LOCKED0: begin
                cnt_next = cnt + CW'(1);
                if (force_release || (win0 && !bus.lock0)) state_next = UNLOCKED;
            end
            LOCKED1: begin
                cnt_next = cnt + CW'(1);
                if (force_release || (win1 && !bus.lock1)) state_next = UNLOCKED;
            end
            default: state_next = UNLOCKED;
        endcase
    end

    always_comb begin
        bus.gnt0       = win0;
        bus.gnt1       = win1;
        bus.memRead    = 1'b0;
        bus.memWrite   = 1'b0;
        bus.lineNumber = '0;
        bus.memIn      = '0;
        if (win0) begin
            bus.memRead    = !bus.we0;
            bus.memWrite   = bus.we0;
            bus.lineNumber = bus.addr0;
            bus.memIn      = bus.wdata0;
        end else if (win1) begin
            bus.memRead    = !bus.we1;
            bus.memWrite   = bus.we1;
            bus.lineNumber = bus.addr1;
            bus.memIn      = bus.wdata1;
        end
        bus.rvalid0 = rvalid0_q && !reset;
        bus.rvalid1 = rvalid1_q && !reset;
        bus.rdata0  = reset ? '0 : bus.memOut;
        bus.rdata1  = reset ? '0 : bus.memOut;
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a per-cycle vector table plus hand-written
// lock-timeout and mid-operation reset sequences, against a 128x8 memory model.
module tb_data_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    data_mem_arbiter_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) bus ();

    data_mem_arbiter #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .LOCK_MAX(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-write, registered-read memory
    logic [7:0] mem [128];
    always @(posedge clk) begin
        if (bus.memWrite) mem[bus.lineNumber] <= bus.memIn;
        if (bus.memRead)  bus.memOut <= mem[bus.lineNumber];
    end

    typedef struct {
        int rst;
        int r0, w0, a0, d0, l0;
        int r1, w1, a1, d1, l1;
        int g0, g1, v0, v1, rd;
        int mr, mw, ln, mi;
    } vec_t;

    vec_t vecs [27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setIdle();
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0; bus.lock0 = 0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0; bus.lock1 = 0;
    endtask

    task automatic applyStimulus(input vec_t v);
        reset      = 1'(v.rst);
        bus.req0   = 1'(v.r0);
        bus.we0    = 1'(v.w0);
        bus.addr0  = 7'(v.a0);
        bus.wdata0 = 8'(v.d0);
        bus.lock0  = 1'(v.l0);
        bus.req1   = 1'(v.r1);
        bus.we1    = 1'(v.w1);
        bus.addr1  = 7'(v.a1);
        bus.wdata1 = 8'(v.d1);
        bus.lock1  = 1'(v.l1);
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        check({tag, "_gnt0"}, 32'(bus.gnt0), 32'(v.g0));
        check({tag, "_gnt1"}, 32'(bus.gnt1), 32'(v.g1));
        check({tag, "_rvalid0"}, 32'(bus.rvalid0), 32'(v.v0));
        check({tag, "_rvalid1"}, 32'(bus.rvalid1), 32'(v.v1));
        check({tag, "_memRead"}, 32'(bus.memRead), 32'(v.mr));
        check({tag, "_memWrite"}, 32'(bus.memWrite), 32'(v.mw));
        check({tag, "_lineNumber"}, 32'(bus.lineNumber), 32'(v.ln));
        if (v.v0 != 0) check({tag, "_rdata0"}, 32'(bus.rdata0), 32'(v.rd));
        if (v.v1 != 0) check({tag, "_rdata1"}, 32'(bus.rdata1), 32'(v.rd));
        if (v.mw != 0) check({tag, "_memIn"}, 32'(bus.memIn), 32'(v.mi));
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        bus.memOut = 8'h00;
        setIdle();

        //            rst r0 w0 a0   d0   l0  r1 w1 a1   d1   l1  g0 g1 v0 v1 rd     mr mw ln   mi
        vecs[0]  = '{1, 1,0,0,  0,    0,  1,0,0,  0,    0,  0,0,0,0,0,     0,0,0,  0};
        vecs[1]  = '{0, 0,0,0,  0,    0,  0,0,0,  0,    0,  0,0,0,0,0,     0,0,0,  0};
        vecs[2]  = '{0, 1,1,3,  'hA5, 0,  0,0,0,  0,    0,  1,0,0,0,0,     0,1,3,  'hA5};
        vecs[3]  = '{0, 0,0,0,  0,    0,  1,0,3,  0,    0,  0,1,0,0,0,     1,0,3,  0};
        vecs[4]  = '{0, 0,0,0,  0,    0,  0,0,0,  0,    0,  0,0,0,1,'hA5,  0,0,0,  0};
        vecs[5]  = '{0, 0,0,0,  0,    0,  0,0,0,  0,    0,  0,0,0,0,0,     0,0,0,  0};
        vecs[6]  = '{0, 1,0,0,  0,    0,  1,1,10, 'h10, 0,  1,0,0,0,0,     1,0,0,  0};
        vecs[7]  = '{0, 1,0,1,  0,    0,  1,1,10, 'h10, 0,  0,1,1,0,0,     0,1,10, 'h10};
        vecs[8]  = '{0, 1,0,1,  0,    0,  1,1,11, 'h11, 0,  1,0,0,0,0,     1,0,1,  0};
        vecs[9]  = '{0, 1,0,2,  0,    0,  1,1,11, 'h11, 0,  0,1,1,0,0,     0,1,11, 'h11};
        vecs[10] = '{0, 1,0,2,  0,    0,  1,1,12, 'h12, 0,  1,0,0,0,0,     1,0,2,  0};
        vecs[11] = '{0, 1,0,3,  0,    0,  1,1,12, 'h12, 0,  0,1,1,0,0,     0,1,12, 'h12};
        vecs[12] = '{0, 1,0,3,  0,    0,  1,1,13, 'h13, 0,  1,0,0,0,0,     1,0,3,  0};
        vecs[13] = '{0, 0,0,0,  0,    0,  1,1,13, 'h13, 0,  0,1,1,0,'hA5,  0,1,13, 'h13};
        vecs[14] = '{0, 1,0,5,  0,    1,  1,0,10, 0,    0,  1,0,0,0,0,     1,0,5,  0};
        vecs[15] = '{0, 0,0,0,  0,    0,  1,0,10, 0,    0,  0,0,1,0,0,     0,0,0,  0};
        vecs[16] = '{0, 0,0,0,  0,    0,  1,0,10, 0,    0,  0,0,0,0,0,     0,0,0,  0};
        vecs[17] = '{0, 1,1,5,  'h5A, 0,  1,0,10, 0,    0,  1,0,0,0,0,     0,1,5,  'h5A};
        vecs[18] = '{0, 0,0,0,  0,    0,  1,0,10, 0,    0,  0,1,0,0,0,     1,0,10, 0};
        vecs[19] = '{0, 0,0,0,  0,    0,  1,0,5,  0,    0,  0,1,0,1,'h10,  1,0,5,  0};
        vecs[20] = '{0, 0,0,0,  0,    0,  0,0,0,  0,    0,  0,0,0,1,'h5A,  0,0,0,  0};
        vecs[21] = '{0, 0,0,0,  0,    0,  1,1,127,'h7F, 0,  0,1,0,0,0,     0,1,127,'h7F};
        vecs[22] = '{0, 0,0,0,  0,    0,  1,1,0,  'hC3, 0,  0,1,0,0,0,     0,1,0,  'hC3};
        vecs[23] = '{0, 1,0,127,0,    0,  0,0,0,  0,    0,  1,0,0,0,0,     1,0,127,0};
        vecs[24] = '{0, 1,0,0,  0,    0,  0,0,0,  0,    0,  1,0,1,0,'h7F,  1,0,0,  0};
        vecs[25] = '{0, 0,0,0,  0,    0,  0,0,0,  0,    0,  0,0,1,0,'hC3,  0,0,0,  0};
        vecs[26] = '{0, 0,0,0,  0,    0,  0,0,0,  0,    0,  0,0,0,0,0,     0,0,0,  0};

        for (int i = 0; i < 27; i++) begin
            step();
            applyStimulus(vecs[i]);
            #1;
            checkOutput(i, vecs[i]);
        end

        // Lock timeout with LOCK_MAX = 4; round-robin pointer currently favours requester 1
        step(); setIdle(); bus.req0 = 1; bus.lock0 = 1; #1;
        check("lockmax_take_gnt0", 32'(bus.gnt0), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            step(); bus.req1 = 1; bus.addr1 = 7'd127; #1;
            check($sformatf("lockmax_hold%0d_gnt0", k), 32'(bus.gnt0), 32'd1);
            check($sformatf("lockmax_hold%0d_gnt1", k), 32'(bus.gnt1), 32'd0);
            check($sformatf("lockmax_hold%0d_rdata0", k), 32'(bus.rdata0), 32'hC3);
        end
        step(); #1;
        check("lockmax_release_gnt0", 32'(bus.gnt0), 32'd0);
        check("lockmax_release_gnt1", 32'(bus.gnt1), 32'd1);
        check("lockmax_release_line", 32'(bus.lineNumber), 32'd127);
        step(); bus.req0 = 0; bus.lock0 = 0; bus.addr1 = 7'd0; #1;
        check("lockmax_after_gnt1", 32'(bus.gnt1), 32'd1);
        check("lockmax_after_rvalid1", 32'(bus.rvalid1), 32'd1);
        check("lockmax_after_rdata1", 32'(bus.rdata1), 32'h7F);
        step(); bus.req1 = 0; bus.req0 = 1; #1;
        check("lockmax_next_gnt0", 32'(bus.gnt0), 32'd1);
        check("lockmax_next_rdata1", 32'(bus.rdata1), 32'hC3);

        // Reset right after a granted read; pointer favours requester 1 going in
        step(); bus.req0 = 0; bus.req1 = 1; bus.addr1 = 7'd127; #1;
        check("rst_pre_gnt1", 32'(bus.gnt1), 32'd1);
        check("rst_pre_rvalid0", 32'(bus.rvalid0), 32'd1);
        step(); reset = 1; bus.req0 = 1; #1;
        check("rst_gnt0", 32'(bus.gnt0), 32'd0);
        check("rst_gnt1", 32'(bus.gnt1), 32'd0);
        check("rst_memRead", 32'(bus.memRead), 32'd0);
        check("rst_memWrite", 32'(bus.memWrite), 32'd0);
        check("rst_lineNumber", 32'(bus.lineNumber), 32'd0);
        check("rst_memIn", 32'(bus.memIn), 32'd0);
        check("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
        check("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
        check("rst_rdata0", 32'(bus.rdata0), 32'd0);
        check("rst_rdata1", 32'(bus.rdata1), 32'd0);
        step(); reset = 0; #1;
        check("rst_post_gnt0", 32'(bus.gnt0), 32'd1);
        check("rst_post_gnt1", 32'(bus.gnt1), 32'd0);
        check("rst_post_rvalid1", 32'(bus.rvalid1), 32'd0);
        step(); #1;
        check("rst_post2_gnt1", 32'(bus.gnt1), 32'd1);
        check("rst_post2_gnt0", 32'(bus.gnt0), 32'd0);
        step(); setIdle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
